// File: rtl/reg_native_if_pkg.sv
// Shared types for the native register responder: FSM states, error causes, latency limit.
package reg_native_if_pkg;
   localparam int ACK_LAT_MAX = 15;
   localparam int CNT_W       = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   typedef struct packed {
      logic oor;
      logic misalign;
      logic badop;
      logic sec;
   } err_cause_t;
endpackage

// File: rtl/reg_native_if_resp_regfile.sv
// Register storage with per-register reset values and one-hot write decode.
module reg_native_if_resp_regfile #(
   parameter int DW       = 32,
   parameter int NUM_REGS = 16,
   parameter int IDXW     = 4,
   parameter logic [NUM_REGS*DW-1:0] RESET_VAL = '0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         soft_rst,
   input  logic                         we,
   input  logic [IDXW-1:0]              widx,
   input  logic [DW-1:0]                wdata,
   output logic [NUM_REGS-1:0][DW-1:0]  regs_q,
   output logic [NUM_REGS-1:0]          wr_pulse
);

   always_comb begin
      wr_pulse = '0;
      for (int i = 0; i < NUM_REGS; i++)
         wr_pulse[i] = we && (widx == IDXW'(i));
   end

   // soft_rst outranks a write landing in the same cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         regs_q <= RESET_VAL;
      else if (soft_rst)
         regs_q <= RESET_VAL;
      else
         for (int i = 0; i < NUM_REGS; i++)
            if (wr_pulse[i]) regs_q[i] <= wdata;
   end

endmodule

// File: rtl/reg_native_if_responder.sv
// Native-bus register responder: one outstanding request, fixed ack latency, error checks.
// Optional security check enabled by defining REG_NATIVE_IF_RESP_SEC_CHECK_EN.
module reg_native_if_responder
   import reg_native_if_pkg::*;
#(
   parameter int BUS_DATA_WIDTH = 32,
   parameter int BUS_ADDR_WIDTH = 48,
   parameter logic [BUS_ADDR_WIDTH-1:0] BASE_ADDR = '0,
   parameter int NUM_REGS    = 16,
   parameter int ACK_LATENCY = 2,
   parameter logic [NUM_REGS-1:0] SECURE_MASK = '0,
   parameter logic [NUM_REGS*BUS_DATA_WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                               native_clk,
   input  logic                               native_rst,
   input  logic                               soft_rst,
   input  logic                               req_vld,
   input  logic [BUS_ADDR_WIDTH-1:0]          addr,
   input  logic                               wr_en,
   input  logic                               rd_en,
   input  logic [BUS_DATA_WIDTH-1:0]          wr_data,
   input  logic                               non_sec,
   output logic                               ack_vld,
   output logic                               err,
   output logic [BUS_DATA_WIDTH-1:0]          rd_data,
   output logic [NUM_REGS*BUS_DATA_WIDTH-1:0] reg_q,
   output logic [NUM_REGS-1:0]                reg_wr_pulse,
   output logic                               drop_sticky
);
   localparam int AW     = BUS_ADDR_WIDTH;
   localparam int DW     = BUS_DATA_WIDTH;
   localparam int STRIDE = DW / 8;
   localparam int SHIFT  = $clog2(STRIDE);
   localparam int IDXW   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [AW-1:0] ALIGN_MASK = AW'(STRIDE - 1);
   localparam logic [AW-1:0] SPAN       = AW'(NUM_REGS * STRIDE);

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [AW-1:0]    addr_q;
   logic [DW-1:0]    wdata_q, rdata_q;
   logic             wr_q, rd_q, nsec_q;
   logic             ack_q, err_q, commit_q, drop_q;

   logic [AW-1:0]    c_addr;
   logic             c_wr, c_rd, c_ns, go_resp, bad;
   logic [AW:0]      diff;
   logic [IDXW-1:0]  idx;
   err_cause_t       cause;
   logic [NUM_REGS-1:0][DW-1:0] regs;

   // Checks look at the live request in IDLE so zero-latency responses need no extra cycle
   always_comb begin
      c_addr = (state_q == IDLE) ? addr    : addr_q;
      c_wr   = (state_q == IDLE) ? wr_en   : wr_q;
      c_rd   = (state_q == IDLE) ? rd_en   : rd_q;
      c_ns   = (state_q == IDLE) ? non_sec : nsec_q;
      diff   = {1'b0, c_addr} - {1'b0, BASE_ADDR};
      idx    = IDXW'(diff[AW-1:0] >> SHIFT);
      cause.oor      = diff[AW] || (diff[AW-1:0] >= SPAN);
      cause.misalign = |(c_addr & ALIGN_MASK);
      cause.badop    = (c_wr == c_rd);
`ifdef REG_NATIVE_IF_RESP_SEC_CHECK_EN
      cause.sec      = c_ns && !cause.oor && SECURE_MASK[idx];
`else
      cause.sec      = 1'b0;
`endif
      bad     = |cause;
      go_resp = ((state_q == IDLE) && req_vld && (ACK_LATENCY == 0)) ||
                ((state_q == WAIT) && (cnt_q == '0));
   end

`ifndef REG_NATIVE_IF_RESP_SEC_CHECK_EN
   logic unused_sec;
   assign unused_sec = ^{c_ns, SECURE_MASK};
`endif

   always_ff @(posedge native_clk or posedge native_rst) begin
      if (native_rst || soft_rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         wr_q     <= 1'b0;
         rd_q     <= 1'b0;
         nsec_q   <= 1'b0;
         ack_q    <= 1'b0;
         err_q    <= 1'b0;
         rdata_q  <= '0;
         commit_q <= 1'b0;
         drop_q   <= 1'b0;
      end else begin
         ack_q    <= 1'b0;
         err_q    <= 1'b0;
         rdata_q  <= '0;
         commit_q <= 1'b0;
         if (req_vld && (state_q != IDLE)) drop_q <= 1'b1;
         case (state_q)
            IDLE: if (req_vld) begin
               addr_q  <= addr;
               wr_q    <= wr_en;
               rd_q    <= rd_en;
               wdata_q <= wr_data;
               nsec_q  <= non_sec;
               state_q <= WAIT;
               cnt_q   <= CNT_W'(ACK_LATENCY - 1);
            end
            WAIT:    if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
            RESP:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
         if (go_resp) begin
            state_q  <= RESP;
            ack_q    <= 1'b1;
            err_q    <= bad;
            rdata_q  <= (!bad && c_rd) ? regs[idx] : '0;
            commit_q <= !bad && c_wr;
         end
      end
   end

   reg_native_if_resp_regfile #(
      .DW(DW), .NUM_REGS(NUM_REGS), .IDXW(IDXW), .RESET_VAL(RESET_VAL)
   ) u_regfile (
      .clk(native_clk), .rst(native_rst), .soft_rst(soft_rst),
      .we(commit_q), .widx(idx), .wdata(wdata_q),
      .regs_q(regs), .wr_pulse(reg_wr_pulse)
   );

   assign ack_vld     = ack_q;
   assign err         = err_q;
   assign rd_data     = rdata_q;
   assign reg_q       = regs;
   assign drop_sticky = drop_q;

endmodule

// File: doc/reg_native_if_responder.md
REG_NATIVE_IF_RESPONDER -- requirements
Module: reg_native_if_responder

Interface
REQ-001 SHALL have parameter BUS_DATA_WIDTH, default 32, data width of wr_data/rd_data and of each register.
REQ-002 SHALL have parameter BUS_ADDR_WIDTH, default 48, byte-address width.
REQ-003 SHALL have parameter BASE_ADDR, default 0, byte address of register 0.
REQ-004 SHALL have parameter NUM_REGS, default 16, register count (1..64).
REQ-005 SHALL have parameter ACK_LATENCY, default 2, wait cycles from accepted request to ack (0..15).
REQ-006 SHALL have parameter SECURE_MASK, default all zeros, NUM_REGS bits; a set bit marks that register secure.
REQ-007 SHALL have parameter RESET_VAL, default all zeros, NUM_REGS*BUS_DATA_WIDTH bits, per-register reset values.
REQ-008 Ports, in this order: native_clk in 1, sole clock; native_rst in 1, reset (one clock; reset is asynchronous and active-high).
REQ-009 Ports: soft_rst in 1, synchronous soft reset; req_vld in 1, request pulse; addr in BUS_ADDR_WIDTH; wr_en in 1; rd_en in 1; wr_data in BUS_DATA_WIDTH; non_sec in 1, request is non-secure.
REQ-010 Ports: ack_vld out 1, response pulse; err out 1, response error; rd_data out BUS_DATA_WIDTH, read data.
REQ-011 Ports: reg_q out NUM_REGS*BUS_DATA_WIDTH, current register contents; reg_wr_pulse out NUM_REGS, one-cycle pulse on a committed write; drop_sticky out 1, request-dropped flag.

Function
REQ-012 Registers SHALL sit at BASE_ADDR + i*(BUS_DATA_WIDTH/8); addr bits below the stride SHALL be zero.
REQ-013 FSM states SHALL be IDLE, WAIT, RESP.
REQ-014 IDLE + req_vld SHALL capture addr, wr_en, rd_en, wr_data and non_sec, then go to WAIT, or to RESP when ACK_LATENCY=0.
REQ-015 WAIT SHALL load a counter with ACK_LATENCY-1, decrement it each cycle, and go to RESP when it is 0.
REQ-016 RESP SHALL last one cycle, assert ack_vld=1 with err and rd_data, commit any write, then go to IDLE.
REQ-017 Latency SHALL be exactly ACK_LATENCY+1 cycles from the req_vld edge to the ack_vld edge.
REQ-018 Only one request SHALL be outstanding; req_vld outside IDLE SHALL be ignored and set drop_sticky, which clears only on reset or soft_rst.
REQ-019 err=1 SHALL result if the address is out of range, misaligned, wr_en==rd_en, or the access fails the security check (REQ-027).
REQ-020 On err=1 there SHALL be no register update, no reg_wr_pulse, and rd_data=0.
REQ-021 A good write SHALL update the register and pulse reg_wr_pulse[i] in the RESP cycle; reg_q SHALL show the new value the next cycle.
REQ-022 A good read SHALL return the register value sampled in the RESP cycle.
REQ-023 Outside RESP, ack_vld=0, err=0 and rd_data=0.
REQ-024 An out-of-range address SHALL be detected with full BUS_ADDR_WIDTH comparison, with no truncation wrap-around.

Reset
REQ-025 native_rst SHALL asynchronously force state IDLE, counter 0, ack_vld=0, err=0, rd_data=0, reg_wr_pulse=0, drop_sticky=0 and registers=RESET_VAL.
REQ-026 soft_rst SHALL apply the same values synchronously with priority over all other events; an in-flight request SHALL be aborted with no ack, and req_vld in the same cycle SHALL be ignored.

Configuration
REQ-027 With macro REG_NATIVE_IF_RESP_SEC_CHECK_EN defined, non_sec=1 to a register with its SECURE_MASK bit set SHALL give err=1, with no write and rd_data=0.
REQ-028 Without REG_NATIVE_IF_RESP_SEC_CHECK_EN, SECURE_MASK and non_sec SHALL be ignored and no security error SHALL occur.

Structure
REQ-029 Package reg_native_if_pkg SHALL hold the FSM state enum, the error-cause typedef (OOR, MISALIGN, BADOP, SEC) and the ACK_LATENCY maximum constant.
REQ-030 Register storage, reset values and write-enable decode SHALL be in sub-module reg_native_if_resp_regfile; the FSM, counter and checks SHALL be in the top module.

Verification
REQ-031 Write 0xA5A5_0001 to BASE+0x8, ACK_LATENCY=2 -> ack_vld on cycle 3 after req, err=0, reg_wr_pulse[2]=1, reg_q reg2=0xA5A5_0001.
REQ-032 Read BASE+0x8 afterwards -> ack_vld with rd_data=0xA5A5_0001 and err=0; read BASE+0x40 with NUM_REGS=16 -> err=1, rd_data=0.
REQ-033 Access to BASE+0x6 -> err=1; request with wr_en=rd_en=1 -> err=1; in both cases no register changes.
REQ-034 SECURE_MASK bit 3 set, non_sec=1 write 0x1234 to reg3 -> err=1 with the macro and reg3 unchanged; without the macro, err=0 and reg3=0x1234.
REQ-035 Second req_vld one cycle after the first -> only one ack, drop_sticky=1; soft_rst in WAIT -> no ack, registers=RESET_VAL, drop_sticky=0.
REQ-036 ACK_LATENCY=0 -> ack_vld exactly 1 cycle after req_vld; native_rst asserted mid-WAIT -> outputs 0 immediately, without waiting for a clock edge.
